// File: rtl/f2c_rsp_engine.sv
// Fabric-to-core request responder: ordered entry buffer feeding the local access port.
// Define F2C_DFD_CNT_EN to build the saturating RdCnt/WrCnt debug counters.
module f2c_rsp_engine #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned PTR_W   = $clog2(ENTRIES)
) (
    input  logic             QClk,
    input  logic             RstQnnnH,
    input  logic             RingReqValid,
    input  logic [1:0]       RingReqOpcode,
    input  logic [31:0]      RingReqAddress,
    input  logic [31:0]      RingReqData,
    input  logic [7:0]       RingReqRequestor,
    output logic             RingReqReady,
    input  logic             MemGnt,
    output logic             MemRdEn,
    output logic             MemWrEn,
    output logic [31:0]      MemAddress,
    output logic [31:0]      MemWrData,
    input  logic [31:0]      MemRdData,
    output logic             RspValid,
    output logic [1:0]       RspOpcode,
    output logic [31:0]      RspAddress,
    output logic [31:0]      RspData,
    output logic [7:0]       RspRequestor,
    input  logic             RspTaken,
    output logic [PTR_W:0]   Occupancy,
    output logic             Error,
    output logic [15:0]      RdCnt,
    output logic [15:0]      WrCnt
);

    typedef enum logic [1:0] {
        OpRd      = 2'b00,
        OpRdRsp   = 2'b01,
        OpWr      = 2'b10,
        OpWrBcast = 2'b11
    } t_opcode;

    typedef enum logic [2:0] {
        StFree      = 3'd0,
        StRead      = 3'd1,
        StReadPrgrs = 3'd2,
        StReadRdy   = 3'd3,
        StWrite     = 3'd4,
        StWriteDone = 3'd5,
        StError     = 3'd6
    } t_state;

    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
    localparam logic [PTR_W:0]   OccOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OccFull = (PTR_W + 1)'(ENTRIES);

    t_state           st_q   [ENTRIES];
    t_state           st_d   [ENTRIES];
    logic [31:0]      addr_q [ENTRIES];
    logic [31:0]      addr_d [ENTRIES];
    logic [31:0]      data_q [ENTRIES];
    logic [31:0]      data_d [ENTRIES];
    logic [7:0]       req_q  [ENTRIES];
    logic [7:0]       req_d  [ENTRIES];

    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] issue_q, issue_d;
    logic [PTR_W-1:0] retire_q, retire_d;
    logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
    logic             rd_pend_q, rd_pend_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             err_q, err_d;

    logic             accept;
    logic             alloc_fire;
    logic             retire_fire;

    assign RingReqReady = (occ_q != OccFull);
    assign accept       = RingReqValid && RingReqReady;
    assign Occupancy    = occ_q;
    assign Error        = err_q;

    always_comb begin
        st_d         = st_q;
        addr_d       = addr_q;
        data_d       = data_q;
        req_d        = req_q;
        alloc_d      = alloc_q;
        issue_d      = issue_q;
        retire_d     = retire_q;
        rd_idx_d     = rd_idx_q;
        rd_pend_d    = 1'b0;
        occ_d        = occ_q;
        err_d        = err_q;
        alloc_fire   = 1'b0;
        retire_fire  = 1'b0;
        MemRdEn      = 1'b0;
        MemWrEn      = 1'b0;
        MemAddress   = '0;
        MemWrData    = '0;
        RspValid     = 1'b0;
        RspOpcode    = '0;
        RspAddress   = '0;
        RspData      = '0;
        RspRequestor = '0;

        // Retire: head entry only, so responses leave in request order.
        case (st_q[retire_q])
            StWriteDone: begin
                st_d[retire_q] = StFree;
                retire_fire    = 1'b1;
            end
            StReadRdy: begin
                RspValid     = 1'b1;
                RspOpcode    = OpRdRsp;
                RspAddress   = addr_q[retire_q];
                RspData      = data_q[retire_q];
                RspRequestor = req_q[retire_q];
                if (RspTaken) begin
                    st_d[retire_q] = StFree;
                    retire_fire    = 1'b1;
                end
            end
            StError: begin
                err_d          = 1'b1;
                st_d[retire_q] = StFree;
                retire_fire    = 1'b1;
            end
            default: ;
        endcase
        if (retire_fire) begin
            retire_d = retire_q + PtrOne;
        end

        // Read data returns one cycle after the strobe.
        if (rd_pend_q) begin
            st_d[rd_idx_q]   = StReadRdy;
            data_d[rd_idx_q] = MemRdData;
        end

        if (MemGnt) begin
            case (st_q[issue_q])
                StRead: begin
                    MemRdEn       = 1'b1;
                    MemAddress    = addr_q[issue_q];
                    st_d[issue_q] = StReadPrgrs;
                    rd_pend_d     = 1'b1;
                    rd_idx_d      = issue_q;
                    issue_d       = issue_q + PtrOne;
                end
                StWrite: begin
                    MemWrEn       = 1'b1;
                    MemAddress    = addr_q[issue_q];
                    MemWrData     = data_q[issue_q];
                    st_d[issue_q] = StWriteDone;
                    issue_d       = issue_q + PtrOne;
                end
                StError: issue_d = issue_q + PtrOne;
                default: ;
            endcase
        end

        if (accept) begin
            case (t_opcode'(RingReqOpcode))
                OpRd: begin
                    st_d[alloc_q] = StRead;
                    alloc_fire    = 1'b1;
                end
                OpWr, OpWrBcast: begin
                    st_d[alloc_q] = StWrite;
                    alloc_fire    = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
            if (alloc_fire) begin
                addr_d[alloc_q] = RingReqAddress;
                data_d[alloc_q] = RingReqData;
                req_d[alloc_q]  = RingReqRequestor;
                alloc_d         = alloc_q + PtrOne;
            end
        end

        if (alloc_fire && !retire_fire) begin
            occ_d = occ_q + OccOne;
        end else if (!alloc_fire && retire_fire) begin
            occ_d = occ_q - OccOne;
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                st_q[i]   <= StFree;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                req_q[i]  <= '0;
            end
            alloc_q   <= '0;
            issue_q   <= '0;
            retire_q  <= '0;
            rd_idx_q  <= '0;
            rd_pend_q <= 1'b0;
            occ_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            req_q     <= req_d;
            alloc_q   <= alloc_d;
            issue_q   <= issue_d;
            retire_q  <= retire_d;
            rd_idx_q  <= rd_idx_d;
            rd_pend_q <= rd_pend_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

`ifdef F2C_DFD_CNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        acc_rd, acc_wr;

    assign acc_rd = accept && (RingReqOpcode == OpRd);
    assign acc_wr = accept && ((RingReqOpcode == OpWr) || (RingReqOpcode == OpWrBcast));

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (acc_rd && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (acc_wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign RdCnt = rd_cnt_q;
    assign WrCnt = wr_cnt_q;
`else
    assign RdCnt = '0;
    assign WrCnt = '0;
`endif

endmodule

// File: tb/tb_f2c_rsp_engine.sv
// Directed bench for f2c_rsp_engine: vector table plus hand-written multi-cycle sequences.
module tb_f2c_rsp_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  req;
    logic        ready;
    logic        gnt;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_req;
    logic        taken;
    logic [2:0]  occ;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    always #5 clk = ~clk;

    f2c_rsp_engine u_dut (
        .QClk             (clk),
        .RstQnnnH         (rst),
        .RingReqValid     (valid),
        .RingReqOpcode    (op),
        .RingReqAddress   (addr),
        .RingReqData      (data),
        .RingReqRequestor (req),
        .RingReqReady     (ready),
        .MemGnt           (gnt),
        .MemRdEn          (mem_rd),
        .MemWrEn          (mem_wr),
        .MemAddress       (mem_addr),
        .MemWrData        (mem_wdata),
        .MemRdData        (rdata),
        .RspValid         (rsp_valid),
        .RspOpcode        (rsp_op),
        .RspAddress       (rsp_addr),
        .RspData          (rsp_data),
        .RspRequestor     (rsp_req),
        .RspTaken         (taken),
        .Occupancy        (occ),
        .Error            (err),
        .RdCnt            (rd_cnt),
        .WrCnt            (wr_cnt)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  req;
        logic        gnt;
        logic [31:0] rdata;
        logic        taken;
        logic        e_ready;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_rsp;
        logic [31:0] e_raddr;
        logic [31:0] e_rdata;
        logic [7:0]  e_rreq;
        logic [2:0]  e_occ;
        logic        e_err;
    } vec_t;

`ifdef F2C_DFD_CNT_EN
    localparam int ExpRd = 3;
    localparam int ExpWr = 2;
`else
    localparam int ExpRd = 0;
    localparam int ExpWr = 0;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   k, first_c, last_c, rd_c, wr_c, hits;
    logic ok;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = 2'd0; addr = '0; data = '0; req = '0;
        gnt = 1'b0; rdata = '0; taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Holds a request until the engine takes it, within a bounded number of cycles.
    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] r);
        valid = 1'b1; op = o; addr = a; data = d; req = r;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = ready;
            next_cycle();
        end
        valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_memrd"}, mem_rd, 0);
        chk({tag, "_memwr"}, mem_wr, 0);
        chk({tag, "_memaddr"}, mem_addr, 0);
        chk({tag, "_memwdata"}, mem_wdata, 0);
        chk({tag, "_rspvalid"}, rsp_valid, 0);
        chk({tag, "_rspop"}, rsp_op, 0);
        chk({tag, "_rspaddr"}, rsp_addr, 0);
        chk({tag, "_rspdata"}, rsp_data, 0);
        chk({tag, "_rspreq"}, rsp_req, 0);
        chk({tag, "_occ"}, occ, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdcnt"}, rd_cnt, 0);
        chk({tag, "_wrcnt"}, wr_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();

        // RD with latency 0..4, then an RD_RSP request raising the sticky error.
        tbl[0] = '{1'b1, 2'd0, 32'h0040_0010, 32'h0, 8'h05, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b1, 1'b0, 32'h0040_0010, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd1, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd1, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0040_0010, 32'hDEADBEEF, 8'h05,
                   3'd1, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0};
        tbl[5] = '{1'b1, 2'd1, 32'h0040_0020, 32'h0, 8'h03, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b1};

        do_reset();
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();

        for (int i = 0; i < 8; i++) begin
            valid = tbl[i].valid; op = tbl[i].op; addr = tbl[i].addr; data = tbl[i].wdata;
            req = tbl[i].req; gnt = tbl[i].gnt; rdata = tbl[i].rdata; taken = tbl[i].taken;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_memrd", i), mem_rd, tbl[i].e_rd);
            chk($sformatf("vec%0d_memwr", i), mem_wr, tbl[i].e_wr);
            chk($sformatf("vec%0d_memaddr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("vec%0d_memwdata", i), mem_wdata, tbl[i].e_mwdata);
            chk($sformatf("vec%0d_rspvalid", i), rsp_valid, tbl[i].e_rsp);
            chk($sformatf("vec%0d_rspop", i), rsp_op, tbl[i].e_rsp ? 2'b01 : 2'b00);
            chk($sformatf("vec%0d_rspaddr", i), rsp_addr, tbl[i].e_raddr);
            chk($sformatf("vec%0d_rspdata", i), rsp_data, tbl[i].e_rdata);
            chk($sformatf("vec%0d_rspreq", i), rsp_req, tbl[i].e_rreq);
            chk($sformatf("vec%0d_occ", i), occ, tbl[i].e_occ);
            chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
            next_cycle();
        end

        // Fill with writes while the port is busy, refuse a fifth, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; op = 2'd2; addr = 32'h0040_0000 + 32'(4 * i); data = 32'(i);
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), ready, 1);
            chk($sformatf("fill%0d_occ", i), occ, 32'(i));
            next_cycle();
        end
        valid = 1'b1; op = 2'd2; addr = 32'h0040_0100; data = 32'h0000_0BAD;
        @(negedge clk);
        chk("full_ready", ready, 0);
        chk("full_occ", occ, 4);
        next_cycle();
        valid = 1'b0; gnt = 1'b1;
        k = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                if (k < 4) begin
                    chk($sformatf("drain%0d_addr", k), mem_addr, 32'h0040_0000 + 32'(4 * k));
                    chk($sformatf("drain%0d_data", k), mem_wdata, 32'(k));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                k++;
            end
            next_cycle();
        end
        chk("drain_pulses", k, 4);
        chk("drain_consecutive", last_c - first_c, 3);
        @(negedge clk);
        chk("drain_occ", occ, 0);
        next_cycle();

        // Younger write issues behind an unreturned read but cannot retire past it.
        do_reset();
        gnt = 1'b1; rdata = 32'h1234_5678;
        rd_c = -1; wr_c = -1;
        for (int c = 0; c < 8; c++) begin
            valid = (c < 2);
            op    = (c == 0) ? 2'd0 : 2'd2;
            addr  = (c == 0) ? 32'h0040_0200 : 32'h0040_0204;
            data  = (c == 0) ? 32'h0 : 32'h55;
            req   = 8'h07;
            @(negedge clk);
            if (mem_rd && rd_c < 0) rd_c = c;
            if (mem_wr && wr_c < 0) wr_c = c;
            next_cycle();
        end
        valid = 1'b0;
        chk("order_rd_seen", (rd_c >= 0), 1);
        chk("order_wr_after_rd", (wr_c > rd_c), 1);
        taken = 1'b1;
        @(negedge clk);
        chk("hold_occ", occ, 2);
        chk("hold_rspvalid", rsp_valid, 1);
        chk("hold_rspdata", rsp_data, 32'h1234_5678);
        chk("hold_rspreq", rsp_req, 8'h07);
        chk("hold_rspaddr", rsp_addr, 32'h0040_0200);
        next_cycle();
        taken = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (occ == 3'd0) ok = 1'b1;
            next_cycle();
        end
        chk("release_drain", ok, 1);

        // Reset while a read is in flight: its data must never surface.
        do_reset();
        gnt = 1'b1; taken = 1'b1; rdata = 32'hCAFE_F00D;
        valid = 1'b1; op = 2'd0; addr = 32'h0040_0300; req = 8'h09;
        next_cycle();
        valid = 1'b0;
        @(negedge clk);
        chk("inflight_memrd", mem_rd, 1);
        chk("inflight_addr", mem_addr, 32'h0040_0300);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        next_cycle();
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
            next_cycle();
        end
        chk("midreset_no_rsp", hits, 0);

        // Debug counters.
        do_reset();
        gnt = 1'b1; taken = 1'b1; rdata = 32'h1;
        send(2'd0, 32'h0040_0400, 32'h0, 8'h01);
        send(2'd3, 32'h0040_0404, 32'h11, 8'h01);
        send(2'd0, 32'h0040_0408, 32'h0, 8'h01);
        send(2'd3, 32'h0040_040C, 32'h22, 8'h01);
        send(2'd0, 32'h0040_0410, 32'h0, 8'h01);
        for (int c = 0; c < 10; c++) next_cycle();
        @(negedge clk);
        chk("cnt_rd", rd_cnt, ExpRd);
        chk("cnt_wr", wr_cnt, ExpWr);
        chk("cnt_occ", occ, 0);
        chk("cnt_err", err, 0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
